// File: rtl/seg_scan_if.sv
// Bundle of display-value, control and shared-decoder signals between the
// numeric datapath/decoder side (master) and the scan controller (slave).
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    lz_blank;
  logic [3:0]              dec_bcd;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    frame_done;

  modport master (
    output en, load, bcd_in, lz_blank, dec_seg,
    input  dec_bcd, seg_out, dig_en, frame_done
  );

  modport slave (
    input  en, load, bcd_in, lz_blank, dec_seg,
    output dec_bcd, seg_out, dig_en, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shares one BCD decoder across
// NUM_DIGITS common-anode digits with blanking gaps and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 1000,
  parameter int BLANK_CYCLES    = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int CntMax = (TICKS_PER_DIGIT > BLANK_CYCLES) ? TICKS_PER_DIGIT : BLANK_CYCLES;
  localparam int TickW  = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SegDark = 7'h7F;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} stateT;

  stateT                   state, stateNext;
  logic [IdxW-1:0]         idx, idxNext;
  logic [TickW-1:0]        tick, tickNext;
  logic [4*NUM_DIGITS-1:0] pending, shadow, shadowNext;
  logic                    lzLatch, lzNext;
  logic [3:0]              decBcd, decBcdNext;
  logic [6:0]              segOut, segNext;
  logic [NUM_DIGITS-1:0]   digEn, digEnNext;
  logic                    frameDone, frameDoneNext;
  logic                    frameStart;
  logic [NUM_DIGITS-1:0]   suppress;

  // A digit is blanked when it and every more-significant nibble are zero.
  always_comb begin
    logic allZero;
    suppress = '0;
    allZero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      allZero     = allZero && (shadow[4*k +: 4] == 4'd0);
      suppress[k] = lzLatch && allZero;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    stateNext     = state;
    idxNext       = idx;
    tickNext      = tick;
    decBcdNext    = decBcd;
    segNext       = segOut;
    digEnNext     = digEn;
    frameDoneNext = 1'b0;
    frameStart    = 1'b0;

    case (state)
      IDLE: begin
        digEnNext = '0;
        segNext   = SegDark;
        if (bus.en) begin
          stateNext  = BLANK;
          idxNext    = '0;
          tickNext   = '0;
          frameStart = 1'b1;
        end
      end
      BLANK: begin
        digEnNext = '0;
        segNext   = SegDark;
        if (tick == TickW'(BLANK_CYCLES - 1)) begin
          stateNext      = DRIVE;
          tickNext       = '0;
          digEnNext[idx] = 1'b1;
          segNext        = suppress[idx] ? SegDark : bus.dec_seg;
        end else begin
          tickNext = tick + 1'b1;
        end
      end
      DRIVE: begin
        if (tick == TickW'(TICKS_PER_DIGIT - 1)) begin
          stateNext = BLANK;
          tickNext  = '0;
          digEnNext = '0;
          segNext   = SegDark;
          if (idx == IdxW'(NUM_DIGITS - 1)) begin
            idxNext       = '0;
            frameStart    = 1'b1;
            frameDoneNext = 1'b1;
          end else begin
            idxNext = idx + 1'b1;
          end
        end else begin
          tickNext = tick + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (!bus.en) begin
      stateNext     = IDLE;
      idxNext       = '0;
      tickNext      = '0;
      digEnNext     = '0;
      segNext       = SegDark;
      frameDoneNext = 1'b0;
      frameStart    = 1'b0;
    end

    // A load in the frame-start cycle itself bypasses the pending register.
    shadowNext = frameStart ? (bus.load ? bus.bcd_in : pending) : shadow;
    lzNext     = frameStart ? bus.lz_blank : lzLatch;

    // Present the nibble on BLANK entry so dec_seg has settled by its last cycle.
    if (stateNext == BLANK && state != BLANK) begin
      decBcdNext = shadowNext[{idxNext, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      tick      <= '0;
      pending   <= '0;
      shadow    <= '0;
      lzLatch   <= 1'b0;
      decBcd    <= 4'd0;
      segOut    <= SegDark;
      digEn     <= '0;
      frameDone <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values,
      // matching real flop behaviour regardless of statement order.
      state     <= stateNext;
      idx       <= idxNext;
      tick      <= tickNext;
      pending   <= bus.load ? bus.bcd_in : pending;
      shadow    <= shadowNext;
      lzLatch   <= lzNext;
      decBcd    <= decBcdNext;
      segOut    <= segNext;
      digEn     <= digEnNext;
      frameDone <= frameDoneNext;
    end
  end

  assign bus.dec_bcd    = decBcd;
  assign bus.seg_out    = segOut;
  assign bus.dig_en     = digEn;
  assign bus.frame_done = frameDone;
endmodule
